mod_hello_arb: RTL and testbench

- Multi-channel successor to the single-channel hello handshake block.
- NUM_CH independent four-phase req/ack channels share one serialised "service" unit with programmable latency.
- Channels are granted round-robin. Each completion is counted per channel and can optionally emit a simulation message.
- Used as a handshake responder and test target for generated controllers in the examples tree.

---
 rtl/mod_hello_arb.sv | 131 +++++++++++++
 tb/tb_mod_hello_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_hello_arb.sv
// Round-robin arbiter serving NUM_CH four-phase req/ack channels through one
// latency-programmable service slot. Define MOD_HELLO_ARB_DISPLAY_EN for completion messages.
module mod_hello_arb #(
    parameter int NUM_CH  = 4,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8,
    parameter int ONCE    = 0,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req,
    output logic [NUM_CH-1:0]       ack,
    output logic                    busy,
    output logic [CH_W-1:0]         last_ch,
    output logic [NUM_CH*CNT_W-1:0] served_cnt
);

    localparam int TMR_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

    state_t              state_q;
    logic [NUM_CH-1:0]   ack_q;
    logic [NUM_CH-1:0]   served_q;
    logic                busy_q;
    logic [CH_W-1:0]     last_ch_q;
    logic [CH_W-1:0]     g_q;
    logic [CH_W-1:0]     rr_q;
    logic [TMR_W-1:0]    timer_q;
    logic [CNT_W-1:0]    cnt_q [NUM_CH];

    logic [NUM_CH-1:0]   elig;
    logic                grant_vld;
    logic [CH_W-1:0]     grant_idx;
    logic [CH_W:0]       sum;
    logic [CH_W-1:0]     g_next;
    logic [CNT_W-1:0]    cnt_inc;
    logic                count_en;

    assign elig     = req & ~ack_q;
    assign g_next   = (g_q == CH_W'(NUM_CH - 1)) ? '0 : g_q + 1'b1;
    assign cnt_inc  = (&cnt_q[g_q]) ? cnt_q[g_q] : cnt_q[g_q] + 1'b1;
    assign count_en = (ONCE == 0) || !served_q[g_q];

    // Scan offsets high to low so the smallest offset from rr_q wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            sum = {1'b0, rr_q} + (CH_W + 1)'(k);
            if (sum >= (CH_W + 1)'(NUM_CH))
                sum = sum - (CH_W + 1)'(NUM_CH);
            if (elig[sum[CH_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = sum[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ack_q     <= '0;
            served_q  <= '0;
            busy_q    <= 1'b0;
            last_ch_q <= '0;
            g_q       <= '0;
            rr_q      <= '0;
            timer_q   <= '0;
            for (int i = 0; i < NUM_CH; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (ack_q[i] && !req[i])
                    ack_q[i] <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        g_q     <= grant_idx;
                        timer_q <= TMR_W'(LATENCY - 1);
                        state_q <= SERVE;
                        busy_q  <= 1'b1;
                    end
                end
                SERVE: begin
                    // A withdrawn request abandons the slot without touching rr_q.
                    if (!req[g_q]) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (timer_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                DONE: begin
                    ack_q[g_q] <= 1'b1;
                    last_ch_q  <= g_q;
                    rr_q       <= g_next;
                    if (count_en) begin
                        cnt_q[g_q]    <= cnt_inc;
                        served_q[g_q] <= 1'b1;
`ifdef MOD_HELLO_ARB_DISPLAY_EN
                        $display("Hello world from channel %0d count %0d", g_q, cnt_inc);
`endif
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack     = ack_q;
    assign busy    = busy_q;
    assign last_ch = last_ch_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt_out
            assign served_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_mod_hello_arb.sv
// Self-checking bench for mod_hello_arb: default, ONCE=1 and CNT_W=2 instances
// share clock and reset; completions on the default instance go through a scoreboard.
module tb_mod_hello_arb;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;

    logic [NUM_CH-1:0]       req = '0;
    logic [NUM_CH-1:0]       ack;
    logic                    busy;
    logic [1:0]              last_ch;
    logic [NUM_CH*CNT_W-1:0] served_cnt;

    logic [NUM_CH-1:0]       req_once = '0;
    logic [NUM_CH-1:0]       ack_once;
    logic                    busy_once;
    logic [1:0]              last_ch_once;
    logic [NUM_CH*CNT_W-1:0] served_cnt_once;

    logic [NUM_CH-1:0]       req_sat = '0;
    logic [NUM_CH-1:0]       ack_sat;
    logic                    busy_sat;
    logic [1:0]              last_ch_sat;
    logic [NUM_CH*2-1:0]     served_cnt_sat;

    int checks = 0;
    int errors = 0;
    int exp_ch[$];
    int exp_cnt[$];
    logic [NUM_CH-1:0] prev_ack = '0;

    always #5 clk = ~clk;

    mod_hello_arb #(.NUM_CH(NUM_CH), .LATENCY(2), .CNT_W(CNT_W), .ONCE(0)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .busy(busy),
        .last_ch(last_ch), .served_cnt(served_cnt)
    );

    mod_hello_arb #(.NUM_CH(NUM_CH), .LATENCY(2), .CNT_W(CNT_W), .ONCE(1)) dut_once (
        .clk(clk), .rst(rst), .req(req_once), .ack(ack_once), .busy(busy_once),
        .last_ch(last_ch_once), .served_cnt(served_cnt_once)
    );

    mod_hello_arb #(.NUM_CH(NUM_CH), .LATENCY(2), .CNT_W(2), .ONCE(0)) dut_sat (
        .clk(clk), .rst(rst), .req(req_sat), .ack(ack_sat), .busy(busy_sat),
        .last_ch(last_ch_sat), .served_cnt(served_cnt_sat)
    );

    // Advance one rising edge, then pop the scoreboard for any new ack on the main instance.
    task automatic tick();
        int ech;
        int ecnt;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) begin
            if (ack[i] && !prev_ack[i]) begin
                checks++;
                if (exp_ch.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_ack ch=%0d expected none", i);
                end else begin
                    ech  = exp_ch.pop_front();
                    ecnt = exp_cnt.pop_front();
                    if (i != ech || int'(last_ch) != ech ||
                        int'(served_cnt[i*CNT_W +: CNT_W]) != ecnt) begin
                        errors++;
                        $display("FAIL sb_completion got ch=%0d last_ch=%0d cnt=%0d expected ch=%0d cnt=%0d",
                                 i, last_ch, served_cnt[i*CNT_W +: CNT_W], ech, ecnt);
                    end
                end
            end
        end
        prev_ack = ack;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic apply_reset();
        checks++;
        if (exp_ch.size() != 0) begin
            errors++;
            $display("FAIL sb_pending got %0d outstanding expected 0", exp_ch.size());
            exp_ch.delete();
            exp_cnt.delete();
        end
        req = '0; req_once = '0; req_sat = '0;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (ack !== '0 || busy !== 1'b0 || last_ch !== '0 || served_cnt !== '0 ||
            ack_once !== '0 || served_cnt_once !== '0 || ack_sat !== '0 || served_cnt_sat !== '0) begin
            errors++;
            $display("FAIL reset_state got ack=%b busy=%b last=%0d cnt=%h expected all zero",
                     ack, busy, last_ch, served_cnt);
        end
    endtask

    task automatic test_single();
        req = 4'b0001;
        exp_ch.push_back(0); exp_cnt.push_back(1);
        ticks(3);
        checks++;
        if (ack !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_early got ack=%b busy=%b expected ack=0000 busy=1", ack, busy);
        end
        tick();
        checks++;
        if (ack !== 4'b0001 || busy !== 1'b0 || served_cnt[0 +: CNT_W] !== 8'd1 || last_ch !== 2'd0) begin
            errors++;
            $display("FAIL single_ack got ack=%b busy=%b cnt0=%0d last=%0d expected 0001 0 1 0",
                     ack, busy, served_cnt[0 +: CNT_W], last_ch);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_release got ack=%b expected 0000", ack);
        end
    endtask

    task automatic test_all_channels();
        logic [NUM_CH-1:0] exp_ack;
        apply_reset();
        req = 4'b1111;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_ch.push_back(c); exp_cnt.push_back(1);
        end
        exp_ack = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ticks(4);
            exp_ack[c] = 1'b1;
            checks++;
            if (ack !== exp_ack) begin
                errors++;
                $display("FAIL all_order step=%0d got ack=%b expected %b", c, ack, exp_ack);
            end
        end
        checks++;
        if (served_cnt[31:0] !== 32'h01010101 || last_ch !== 2'd3) begin
            errors++;
            $display("FAIL all_counts got cnt=%h last=%0d expected 01010101 3", served_cnt, last_ch);
        end
        req = 4'b0000;
        tick();
        // rr pointer back at 0: channel 1 must win over channel 3.
        req = 4'b1010;
        exp_ch.push_back(1); exp_cnt.push_back(2);
        exp_ch.push_back(3); exp_cnt.push_back(2);
        ticks(4);
        checks++;
        if (ack !== 4'b0010) begin
            errors++;
            $display("FAIL rr_wrap got ack=%b expected 0010", ack);
        end
        ticks(4);
        checks++;
        if (ack !== 4'b1010) begin
            errors++;
            $display("FAIL rr_second got ack=%b expected 1010", ack);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_abort();
        apply_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_grant got busy=%b expected 1", busy);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b expected 0", busy);
        end
        ticks(4);
        checks++;
        if (ack !== 4'b0000 || served_cnt[2*CNT_W +: CNT_W] !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_result got ack=%b cnt2=%0d busy=%b expected 0000 0 0",
                     ack, served_cnt[2*CNT_W +: CNT_W], busy);
        end
    endtask

    task automatic test_once();
        apply_reset();
        for (int k = 1; k <= 3; k++) begin
            req_once = 4'b0010;
            ticks(4);
            checks++;
            if (ack_once !== 4'b0010 || served_cnt_once[CNT_W +: CNT_W] !== 8'd1) begin
                errors++;
                $display("FAIL once_hs%0d got ack=%b cnt1=%0d expected 0010 1",
                         k, ack_once, served_cnt_once[CNT_W +: CNT_W]);
            end
            req_once = 4'b0000;
            tick();
            checks++;
            if (ack_once !== 4'b0000) begin
                errors++;
                $display("FAIL once_release%0d got ack=%b expected 0000", k, ack_once);
            end
        end
    endtask

    task automatic test_saturate();
        int exp_c;
        apply_reset();
        for (int k = 1; k <= 5; k++) begin
            exp_c = (k > 3) ? 3 : k;
            req_sat = 4'b1000;
            ticks(4);
            checks++;
            if (ack_sat !== 4'b1000 || int'(served_cnt_sat[6 +: 2]) != exp_c) begin
                errors++;
                $display("FAIL sat_hs%0d got ack=%b cnt3=%0d expected 1000 %0d",
                         k, ack_sat, served_cnt_sat[6 +: 2], exp_c);
            end
            req_sat = 4'b0000;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 4'b0010;
        exp_ch.push_back(1); exp_cnt.push_back(1);
        ticks(4);
        req = 4'b0011;
        ticks(2);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ack !== '0 || busy !== 1'b0 || last_ch !== '0 || served_cnt !== '0) begin
            errors++;
            $display("FAIL async_reset got ack=%b busy=%b last=%0d cnt=%h expected all zero",
                     ack, busy, last_ch, served_cnt);
        end
        @(negedge clk);
        prev_ack = ack;
        req = 4'b0001;
        rst = 1'b0;
        exp_ch.push_back(0); exp_cnt.push_back(1);
        ticks(3);
        checks++;
        if (ack !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_early got ack=%b expected 0000", ack);
        end
        tick();
        checks++;
        if (ack !== 4'b0001 || served_cnt[0 +: CNT_W] !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_ack got ack=%b cnt0=%0d expected 0001 1",
                     ack, served_cnt[0 +: CNT_W]);
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_channels();
        test_abort();
        test_once();
        test_saturate();
        test_reset_mid();
        checks++;
        if (exp_ch.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d outstanding expected 0", exp_ch.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
